// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
// Bundles the two bus-style connections of the instruction-memory loader:
//   - byte stream   : in_valid / in_data from the source, in_ready back to it
//   - memory write  : mem_we / mem_addr / mem_wdata towards instruction memory
// Modports:
//   master : the loader side (consumes bytes, drives the memory write port)
//   slave  : the environment side (byte source + instruction memory)
// Parameter:
//   ADDR_W : instruction memory word-address width
// -----------------------------------------------------------------------------
interface imem_loader_if #(
    parameter int ADDR_W = 6
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Writer side of the instruction memory. Receives a byte stream of the form
//   N, then 4*N data bytes (little-endian words)
// and writes each assembled 32-bit word to consecutive word addresses starting
// at 0. The core is held in reset (o_cpu_hold) until a load completes.
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//   When defined, one trailing checksum byte C follows the data; the load
//   succeeds only if (sum of data bytes + C) mod 256 == 0.
//
// Ports:
//   i_clk          : system clock, rising edge
//   i_rst          : synchronous active-high reset
//   i_start        : one-cycle pulse, begins a session from IDLE/DONE/ERR
//   bus            : imem_loader_if.master (byte stream + memory write port)
//   o_cpu_hold     : holds the core in reset while high
//   o_busy         : high while a session is in progress
//   o_done         : load completed successfully (level)
//   o_err          : load aborted (level)
//   o_words_loaded : words written in the current session
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    imem_loader_if.master     bus,
    output logic              o_cpu_hold,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [ADDR_W:0]   o_words_loaded
);

    localparam int WL_W  = ADDR_W + 1;
    // common width for comparing the word counter with the 8-bit count byte
    localparam int CMP_W = (WL_W > 8) ? WL_W : 8;
    localparam logic [8:0] DEPTH_C = 9'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_BYTES = 3'd2,
        ST_WRITE = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHK   = 3'd4,
`endif
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_t;

    // state entered once the last word (or an empty image) has been handled
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t ST_FINAL = ST_CHK;
`else
    localparam state_t ST_FINAL = ST_DONE;
`endif

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_in_ready;
    logic               w_xfer;
    logic [WL_W-1:0]    w_wl_inc;
    logic               w_last_word;
    logic               w_we_nxt;
    logic               w_hold_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic               w_err_nxt;

    logic [7:0]         r_n;
    logic [1:0]         r_lane;
    logic [23:0]        r_word;     // lanes 0..2; lane 3 goes straight to mem_wdata
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [31:0]        r_mem_wdata;
    logic               r_cpu_hold;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic [WL_W-1:0]    r_words_loaded;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]         r_sum;
    logic [7:0]         w_sum_fin;
    assign w_sum_fin = r_sum + bus.in_data;
`endif

    assign w_xfer      = bus.in_valid & w_in_ready;
    assign w_wl_inc    = r_words_loaded + WL_W'(1);
    assign w_last_word = (CMP_W'(w_wl_inc) == CMP_W'(r_n));

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) w_state_nxt = ST_LEN;
                else         w_state_nxt = ST_IDLE;
            end
            ST_LEN: begin
                if (!w_xfer)                           w_state_nxt = ST_LEN;
                else if (bus.in_data == 8'd0)          w_state_nxt = ST_FINAL;
                else if ({1'b0, bus.in_data} > DEPTH_C) w_state_nxt = ST_ERR;
                else                                   w_state_nxt = ST_BYTES;
            end
            ST_BYTES: begin
                if (w_xfer && (r_lane == 2'd3)) w_state_nxt = ST_WRITE;
                else                            w_state_nxt = ST_BYTES;
            end
            ST_WRITE: begin
                if (w_last_word) w_state_nxt = ST_FINAL;
                else             w_state_nxt = ST_BYTES;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (!w_xfer)                w_state_nxt = ST_CHK;
                else if (w_sum_fin == 8'd0) w_state_nxt = ST_DONE;
                else                        w_state_nxt = ST_ERR;
            end
`endif
            ST_DONE, ST_ERR: begin
                if (i_start) w_state_nxt = ST_LEN;
                else         w_state_nxt = r_state;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode: in_ready from current state, registered outputs from next state
    always_comb begin
        w_in_ready = 1'b0;
        case (r_state)
            ST_LEN, ST_BYTES: w_in_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHK:           w_in_ready = 1'b1;
`endif
            default:          w_in_ready = 1'b0;
        endcase

        w_we_nxt   = 1'b0;
        w_hold_nxt = 1'b1;
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        w_err_nxt  = 1'b0;
        case (w_state_nxt)
            ST_LEN, ST_BYTES: w_busy_nxt = 1'b1;
            ST_WRITE: begin
                w_busy_nxt = 1'b1;
                w_we_nxt   = 1'b1;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHK:           w_busy_nxt = 1'b1;
`endif
            ST_DONE: begin
                w_done_nxt = 1'b1;
                w_hold_nxt = 1'b0;
            end
            ST_ERR:           w_err_nxt  = 1'b1;
            default:          w_busy_nxt = 1'b0;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_n            <= 8'd0;
            r_lane         <= 2'd0;
            r_word         <= 24'd0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= 32'd0;
            r_cpu_hold     <= 1'b1;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_err          <= 1'b0;
            r_words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum          <= 8'd0;
`endif
        end else begin
            r_mem_we   <= w_we_nxt;
            r_cpu_hold <= w_hold_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;

            if ((r_state == ST_LEN) && w_xfer) begin
                r_n            <= bus.in_data;
                r_lane         <= 2'd0;
                r_word         <= 24'd0;
                r_words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                r_sum          <= 8'd0;
`endif
            end else if ((r_state == ST_BYTES) && w_xfer) begin
                r_lane <= r_lane + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                r_sum  <= w_sum_fin;
`endif
                case (r_lane)
                    2'd0: r_word[7:0]   <= bus.in_data;
                    2'd1: r_word[15:8]  <= bus.in_data;
                    2'd2: r_word[23:16] <= bus.in_data;
                    default: begin
                        // last lane: present the complete word for the WRITE cycle
                        r_mem_addr  <= r_words_loaded[ADDR_W-1:0];
                        r_mem_wdata <= {bus.in_data, r_word};
                    end
                endcase
            end else if (r_state == ST_WRITE) begin
                r_words_loaded <= w_wl_inc;
            end
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.mem_we      = r_mem_we;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_wdata   = r_mem_wdata;
    assign o_cpu_hold      = r_cpu_hold;
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_err           = r_err;
    assign o_words_loaded  = r_words_loaded;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Scoreboard bench for imem_loader: each session's expected memory writes are
// derived from the byte image and queued before streaming; a monitor pops and
// compares on every mem_we pulse. Session outcome (done/err/cpu_hold/count) is
// checked against the expected result of the load rules.
// -----------------------------------------------------------------------------
module tb_imem_loader;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   words_loaded;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus();

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .bus            (bus),
        .o_cpu_hold     (cpu_hold),
        .o_busy         (busy),
        .o_done         (done),
        .o_err          (err),
        .o_words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [31:0]       exp_data_q[$];
    logic [7:0]        data_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write pulse must match the oldest expected write
    always @(negedge clk) begin
        logic [ADDR_W-1:0] ea;
        logic [31:0]       ed;
        if (bus.mem_we === 1'b1) begin
            chk("in_ready_low_in_write", 64'(bus.in_ready), 64'(1'b0));
            if (exp_addr_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                ea = exp_addr_q.pop_front();
                ed = exp_data_q.pop_front();
                chk("write_addr", 64'(bus.mem_addr), 64'(ea));
                chk("write_data", 64'(bus.mem_wdata), 64'(ed));
            end
        end
    end

    task automatic fill_random(input int n);
        data_q.delete();
        for (int j = 0; j < 4 * n; j++) data_q.push_back(8'($urandom_range(0, 255)));
    endtask

    // Offer one byte and hold it until accepted; returns on the negedge after the transfer
    task automatic send_byte(input logic [7:0] b, input bit gappy, input bit poke);
        int budget;
        if (gappy) begin
            int g = $urandom_range(0, 2);
            repeat (g) @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        if (poke) start = 1'b1;
        budget = 0;
        while (bus.in_ready !== 1'b1 && budget < 100) begin
            @(negedge clk);
            start = 1'b0;
            budget++;
        end
        if (budget >= 100) begin
            checks++;
            failures++;
            $display("FAIL byte_accept_timeout: in_ready stayed 0 for byte 0x%0h", b);
        end
        @(negedge clk);
        start        = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    // One complete load session using the bytes in data_q for n words
    task automatic run_session(input int n, input bit gappy, input bit poke, input int corrupt);
        int sum;
        int cnt;
        bit exp_err;
        int exp_wl;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", 64'(busy), 64'(1'b1));
        chk("start_hold", 64'(cpu_hold), 64'(1'b1));
        chk("start_done", 64'(done), 64'(1'b0));
        chk("start_err", 64'(err), 64'(1'b0));
        send_byte(8'(n), gappy, 1'b0);
        exp_err = 1'b0;
        exp_wl  = n;
        if (n > DEPTH) begin
            exp_err = 1'b1;
            exp_wl  = 0;
        end else begin
            for (int i = 0; i < n; i++) begin
                exp_addr_q.push_back(ADDR_W'(i));
                exp_data_q.push_back({data_q[4*i+3], data_q[4*i+2], data_q[4*i+1], data_q[4*i]});
            end
            sum = 0;
            for (int j = 0; j < 4 * n; j++) begin
                send_byte(data_q[j], gappy, poke && (j == 1));
                sum += int'(data_q[j]);
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            send_byte(8'(corrupt - sum), gappy, 1'b0);
            exp_err = (corrupt != 0);
`endif
        end
        cnt = 0;
        while (done !== 1'b1 && err !== 1'b1 && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 50) begin
            checks++;
            failures++;
            $display("FAIL session_end_timeout: neither done nor err after n=%0d", n);
        end
        chk("end_done", 64'(done), 64'(!exp_err));
        chk("end_err", 64'(err), 64'(exp_err));
        chk("end_hold", 64'(cpu_hold), 64'(exp_err));
        chk("end_busy", 64'(busy), 64'(1'b0));
        chk("end_in_ready", 64'(bus.in_ready), 64'(1'b0));
        chk("end_words_loaded", 64'(words_loaded), 64'(exp_wl));
        chk("end_pending_writes", 64'(exp_addr_q.size()), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'(1'b0));
        chk("rst_mem_we", 64'(bus.mem_we), 64'(1'b0));
        chk("rst_mem_addr", 64'(bus.mem_addr), 64'(0));
        chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'(0));
        chk("rst_busy", 64'(busy), 64'(1'b0));
        chk("rst_done", 64'(done), 64'(1'b0));
        chk("rst_err", 64'(err), 64'(1'b0));
        chk("rst_hold", 64'(cpu_hold), 64'(1'b1));
        chk("rst_words_loaded", 64'(words_loaded), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 64'(bus.in_ready), 64'(1'b0));

        // two-word directed image
        data_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h00, 8'h00};
        run_session(2, 1'b0, 1'b0, 0);

        // oversize count aborts, then a good load recovers
        data_q.delete();
        run_session(65, 1'b0, 1'b0, 0);
        fill_random(1);
        run_session(1, 1'b0, 1'b0, 0);

        // single word with a stalling source
        fill_random(1);
        run_session(1, 1'b1, 1'b0, 0);

        // reset after 6 data bytes: only word 0 reaches memory
        fill_random(2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'd2, 1'b0, 1'b0);
        exp_addr_q.push_back(ADDR_W'(0));
        exp_data_q.push_back({data_q[3], data_q[2], data_q[1], data_q[0]});
        for (int j = 0; j < 6; j++) send_byte(data_q[j], 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 64'(busy), 64'(1'b0));
        chk("midrst_hold", 64'(cpu_hold), 64'(1'b1));
        chk("midrst_done", 64'(done), 64'(1'b0));
        chk("midrst_in_ready", 64'(bus.in_ready), 64'(1'b0));
        chk("midrst_pending_writes", 64'(exp_addr_q.size()), 64'(0));
        @(negedge clk);
        chk("midrst_no_write_after", 64'(bus.mem_we), 64'(1'b0));

        // reload after reset, then reload from DONE
        fill_random(3);
        run_session(3, 1'b0, 1'b0, 0);
        fill_random(1);
        run_session(1, 1'b0, 1'b0, 0);

        // full memory, empty image, count far above depth
        fill_random(DEPTH);
        run_session(DEPTH, 1'b0, 1'b0, 0);
        data_q.delete();
        run_session(0, 1'b0, 1'b0, 0);
        run_session(255, 1'b0, 1'b0, 0);

        // random sessions, with stray start pulses mid-stream
        for (int s = 0; s < 8; s++) begin
            int n;
            n = $urandom_range(1, 8);
            fill_random(n);
            run_session(n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        data_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_session(1, 1'b0, 1'b0, 0);
        data_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_session(1, 1'b0, 1'b0, 1);
        fill_random(3);
        run_session(3, 1'b1, 1'b0, 0);
`endif

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
